// File: rtl/joypad_poller.sv
// rtl/joypad_poller.sv - NES joypad poller: latch, 16-bit serial scan, pad detection, periodic repoll
module joypad_poller #(
  parameter int LATCH_CYC = 252,
  parameter int HALF_CYC  = 126,
  parameter int POLL_CYC  = 357954
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] joy,
  output logic       pad_present,
  output logic       valid
);

  localparam int PW    = ($clog2(POLL_CYC + 1) > 19) ? $clog2(POLL_CYC + 1) : 19;
  localparam int PHMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int PHW   = $clog2(PHMAX + 1);

  // One-hot so pad_latch, pad_clk and valid come straight off a state flop.
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_LATCH  = 6'b000010,
    S_LOW    = 6'b000100,
    S_HIGH   = 6'b001000,
    S_UPDATE = 6'b010000,
    S_WAIT   = 6'b100000
  } state_t;

  state_t          state, state_next;
  logic            sync1, pad_s;
  logic [PHW-1:0]  ph_cnt;
  logic [PW-1:0]   poll_cnt;
  logic [3:0]      idx;
  logic [15:0]     shift;
  logic            phase_last;
  logic            in_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    in_phase   = (state == S_LATCH) || (state == S_LOW) || (state == S_HIGH);
    phase_last = (state == S_LATCH) ? (ph_cnt == PHW'(LATCH_CYC - 1))
                                    : (ph_cnt == PHW'(HALF_CYC - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (enable) state_next = S_LATCH;
      S_LATCH:  if (phase_last) state_next = S_LOW;
      S_LOW:    if (phase_last) state_next = S_HIGH;
      S_HIGH:   if (phase_last) state_next = (idx == 4'd15) ? S_UPDATE : S_LOW;
      S_UPDATE: state_next = S_WAIT;
      S_WAIT:   if (poll_cnt == PW'(POLL_CYC - 1)) state_next = enable ? S_LATCH : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pad_latch = state[1];
    pad_clk   = state[3];
    valid     = state[4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= 1'b0;
      pad_s       <= 1'b0;
      ph_cnt      <= '0;
      poll_cnt    <= '0;
      idx         <= '0;
      shift       <= '0;
      joy         <= 8'h00;
      pad_present <= 1'b0;
    end else begin
      sync1 <= pad_data;
      pad_s <= sync1;

      if (in_phase && !phase_last) ph_cnt <= ph_cnt + PHW'(1);
      else                         ph_cnt <= '0;

      // Period is measured from the first latch-high cycle.
      if (state_next == S_LATCH && state != S_LATCH) poll_cnt <= '0;
      else if (state != S_IDLE)                      poll_cnt <= poll_cnt + PW'(1);

      if (state == S_LATCH)                  idx <= '0;
      else if (state == S_HIGH && phase_last) idx <= idx + 4'd1;

      if (state == S_LOW && phase_last) shift[idx] <= ~pad_s;

      // Results land together with the UPDATE cycle so valid and joy align.
      if (state == S_HIGH && phase_last && idx == 4'd15) begin
        pad_present <= &shift[15:8];
        joy         <= (&shift[15:8]) ? shift[7:0] : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_joypad_poller.sv
// tb/tb_joypad_poller.sv - directed bench for joypad_poller with a 4021-style pad model
module tb_joypad_poller;

  localparam int LC = 4;
  localparam int HC = 3;
  localparam int PC = 200;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] joy;
  logic       pad_present;
  logic       valid;

  int total = 0;
  int bad   = 0;

  logic [15:0] pad_bits;
  logic        disc;
  int          pidx = 0;

  int   k;
  int   pulses;
  int   badrun;
  int   run;
  int   overlap;
  logic prev_clk;

  joypad_poller #(.LATCH_CYC(LC), .HALF_CYC(HC), .POLL_CYC(PC)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .joy(joy),
    .pad_present(pad_present), .valid(valid)
  );

  always #5 clk = ~clk;

  // Pad: latch reloads bit 0, each pad_clk rise advances; beyond 16 the serial input is grounded.
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pidx <= 0;
    else           pidx <= pidx + 1;
  end
  assign pad_data = disc ? 1'b1 : ((pidx < 16) ? ~pad_bits[pidx[3:0]] : 1'b0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    k++;
    if (pad_latch && pad_clk) overlap++;
    if (pad_clk) run++;
    else if (prev_clk) begin
      pulses++;
      if (run != HC) badrun++;
      run = 0;
    end
    prev_clk = pad_clk;
  endtask

  task automatic reset_mon();
    k = 0; pulses = 0; badrun = 0; run = 0; prev_clk = pad_clk;
  endtask

  task automatic wait_for(input int sel, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (((sel == 0) ? pad_latch : valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int lw;
    overlap  = 0;
    reset_mon();
    reset_n  = 1'b0;
    enable   = 1'b0;
    disc     = 1'b0;
    pad_bits = 16'hFF09;
    repeat (3) @(negedge clk);
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 0);
    chk("rst_joy", joy, 0);
    chk("rst_present", pad_present, 0);
    chk("rst_valid", valid, 0);

    // Scan timing with A+Start pressed
    reset_n = 1'b1;
    enable  = 1'b1;
    step();
    chk("first_latch", pad_latch, 1);
    reset_mon();
    lw = 0;
    for (int i = 0; i < 20 && pad_latch; i++) begin
      lw++;
      step();
    end
    chk("latch_width", lw, LC);
    wait_for(1, 150, ok);
    chk("valid_seen1", ok, 1);
    chk("update_cycle", k, 100);
    chk("joy_astart", joy, 8'h09);
    chk("present_std", pad_present, 1);
    chk("clk_pulses", pulses, 16);
    chk("clk_high_width", badrun, 0);
    chk("clk_low_update", pad_clk, 0);
    step();
    chk("valid_one_cycle", valid, 0);
    chk("joy_hold", joy, 8'h09);
    wait_for(0, 250, ok);
    chk("relatch_seen", ok, 1);
    chk("poll_period", k, PC);

    // Disconnected pad
    reset_mon();
    disc = 1'b1;
    wait_for(1, 150, ok);
    chk("valid_disc", ok, 1);
    chk("disc_cycle", k, 100);
    chk("joy_disc", joy, 8'h00);
    chk("present_disc", pad_present, 0);

    // Non-standard pad: bit 8 released
    disc     = 1'b0;
    pad_bits = 16'hFEFF;
    wait_for(0, 150, ok);
    chk("period2", k, PC);
    reset_mon();
    wait_for(1, 150, ok);
    chk("valid_nonstd", ok, 1);
    chk("joy_nonstd", joy, 8'h00);
    chk("present_nonstd", pad_present, 0);

    // Enable dropped during LOW of bit 4
    pad_bits = 16'hFF30;
    wait_for(0, 150, ok);
    chk("latch_t4", ok, 1);
    reset_mon();
    while (k < 29) step();
    chk("in_low5", pad_clk, 0);
    enable = 1'b0;
    wait_for(1, 150, ok);
    chk("valid_drop", ok, 1);
    chk("drop_cycle", k, 100);
    chk("joy_drop", joy, 8'h30);
    chk("present_drop", pad_present, 1);
    wait_for(0, 250, ok);
    chk("no_relatch", ok, 0);
    chk("joy_idle_hold", joy, 8'h30);

    // Reset during HIGH of bit 10
    enable = 1'b1;
    step();
    chk("idle_restart", pad_latch, 1);
    reset_mon();
    while (k < 68) step();
    chk("in_high10", pad_clk, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_clk", pad_clk, 0);
    chk("mid_rst_latch", pad_latch, 0);
    chk("mid_rst_joy", joy, 0);
    chk("mid_rst_present", pad_present, 0);
    chk("mid_rst_valid", valid, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_latch", pad_latch, 1);
    chk("post_rst_joy", joy, 0);
    reset_mon();
    wait_for(1, 150, ok);
    chk("valid_post_rst", ok, 1);
    chk("post_rst_cycle", k, 100);
    chk("joy_post_rst", joy, 8'h30);
    chk("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
